// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC transaction scheduler: record layout,
// header bit positions, size encoding and byte helpers.
package lpc_pkg;

    localparam int         REC_W         = 72;
    localparam logic [7:0] TERM_BYTE_DEF = 8'h0A;

    localparam int HDR_CYC_LSB  = 4;
    localparam int HDR_LOST_BIT = 3;
    localparam int HDR_SIZE_LSB = 0;

    typedef struct packed {
        logic        lost;
        logic [3:0]  cyctype_dir;
        logic [2:0]  data_size;
        logic [31:0] addr;
        logic [31:0] data;
    } lpc_rec_t;

    // Unsupported sizes (3,5,6,7) are sent as full 4-byte words.
    function automatic logic [2:0] size_code(input logic [2:0] data_size);
        logic [2:0] code;
        case (data_size)
            3'd0:    code = 3'd0;
            3'd1:    code = 3'd1;
            3'd2:    code = 3'd2;
            default: code = 3'd4;
        endcase
        return code;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] make_hdr(input lpc_rec_t rec);
        logic [7:0] h;
        h                                   = 8'h00;
        h[HDR_CYC_LSB +: 4]                 = rec.cyctype_dir;
        h[HDR_LOST_BIT]                     = rec.lost;
        h[HDR_SIZE_LSB +: 3]                = size_code(rec.data_size);
        return h;
    endfunction

endpackage

// File: rtl/lpc_txn_fifo.sv
// Synchronous record FIFO; a push while full is taken when a pop happens
// in the same cycle, so the level stays unchanged.
module lpc_txn_fifo
    import lpc_pkg::*;
#(
    parameter int AW = 3,
    parameter int W  = REC_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  level_o
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          pop_s;
    logic          push_s;

    assign empty_o = (level_q == {(AW + 1){1'b0}});
    assign full_o  = (level_q == LVL_FULL);
    assign pop_s   = pop_i & ~empty_o;
    assign push_s  = push_i & (~full_o | pop_s);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lpc_txn_scheduler.sv
// Buffers decoded LPC transactions and serialises each as a framed byte
// record (header, address, data, terminator) onto a ready/valid byte link.
module lpc_txn_scheduler
    import lpc_pkg::*;
#(
    parameter int         FIFO_AW   = 3,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEF
) (
    input  logic               lpc_clock,
    input  logic               lpc_reset,
    input  logic               in_valid,
    input  logic [3:0]         in_cyctype_dir,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_data,
    input  logic [2:0]         in_data_size,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [7:0]         drop_count,
    output logic               busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_ADDR = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_TERM = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    lpc_rec_t         rec_q, rec_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             lost_q, lost_d;
    logic [7:0]       drop_q, drop_d;

    lpc_rec_t         fifo_wdata_s;
    logic [REC_W-1:0] fifo_rdata_s;
    logic             full_s, empty_s, pop_s, push_s, drop_s, accept_s;
    logic [2:0]       n_bytes_s;
    logic [1:0]       last_idx_s;
    logic [FIFO_AW:0] level_s;

    assign push_s     = in_valid & (~full_s | pop_s);
    assign drop_s     = in_valid & ~push_s;
    assign accept_s   = tx_valid_q & tx_ready;
    assign n_bytes_s  = size_code(rec_q.data_size);
    // Wraps 4 -> 3, which is exactly the last index of a 4-byte payload.
    assign last_idx_s = n_bytes_s[1:0] - 2'd1;

    // Record captured on every strobe; the pending lost flag rides along.
    always_comb begin
        fifo_wdata_s.lost        = lost_q;
        fifo_wdata_s.cyctype_dir = in_cyctype_dir;
        fifo_wdata_s.data_size   = in_data_size;
        fifo_wdata_s.addr        = in_addr;
        fifo_wdata_s.data        = in_data;
    end

    lpc_txn_fifo #(
        .AW (FIFO_AW),
        .W  (REC_W)
    ) u_fifo (
        .clk_i   (lpc_clock),
        .rst_i   (lpc_reset),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Lost flag and saturating drop counter.
    always_comb begin
        if (drop_s) begin
            lost_d = 1'b1;
        end else if (push_s) begin
            lost_d = 1'b0;
        end else begin
            lost_d = lost_q;
        end
        if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Frame FSM and byte mux; tx_data is loaded one state ahead so it is registered.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rec_d      = rec_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pop_s      = 1'b1;
                rec_d      = lpc_rec_t'(fifo_rdata_s);
                tx_data_d  = make_hdr(lpc_rec_t'(fifo_rdata_s));
                tx_valid_d = 1'b1;
                state_d    = ST_HDR;
            end
            ST_HDR: begin
                if (accept_s) begin
                    state_d   = ST_ADDR;
                    idx_d     = 2'd3;
                    tx_data_d = byte_sel(rec_q.addr, 2'd3);
                end else begin
                    state_d   = ST_HDR;
                end
            end
            ST_ADDR: begin
                if (!accept_s) begin
                    state_d   = ST_ADDR;
                end else if (idx_q != 2'd0) begin
                    idx_d     = idx_q - 2'd1;
                    tx_data_d = byte_sel(rec_q.addr, idx_q - 2'd1);
                end else if (n_bytes_s == 3'd0) begin
                    state_d   = ST_TERM;
                    tx_data_d = TERM_BYTE;
                end else begin
                    state_d   = ST_DATA;
                    idx_d     = 2'd0;
                    tx_data_d = byte_sel(rec_q.data, 2'd0);
                end
            end
            ST_DATA: begin
                if (!accept_s) begin
                    state_d   = ST_DATA;
                end else if (idx_q == last_idx_s) begin
                    state_d   = ST_TERM;
                    tx_data_d = TERM_BYTE;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    tx_data_d = byte_sel(rec_q.data, idx_q + 2'd1);
                end
            end
            ST_TERM: begin
                if (accept_s) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end else begin
                    state_d    = ST_TERM;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any partial frame.
    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            rec_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            lost_q     <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rec_q      <= rec_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            lost_q     <= lost_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_level = level_s;
    assign drop_count = drop_q;
    assign busy       = (state_q != ST_IDLE) | (|level_s);

endmodule
